// File: rtl/base_emux_pkg.sv
// Shared sizing and pointer helpers for the emux output credit buffer.
package base_emux_pkg;

    // Width needed to hold a count in the range 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width. A one-entry FIFO still gets a 1-bit pointer.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Advance a FIFO pointer and wrap explicitly at depth-1, so depth
    // does not have to be a power of two.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/base_credit_cnt.sv
// Up/down credit counter with reset-time initial value.
// A decrement is taken only while the registered count is non-zero.
// A decrement request at zero is dropped and raises a sticky error.
//  clk, rst_n  clock, async active-low reset
//  dec         consume one credit (rejected when count == 0)
//  inc         return one credit
//  count       current credit count
//  nz          registered (count != 0)
//  err         sticky: dec requested while count == 0
module base_credit_cnt #(
    parameter int unsigned cnt_width = 4,
    parameter int unsigned init_val  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec,
    input  logic                 inc,
    output logic [cnt_width-1:0] count,
    output logic                 nz,
    output logic                 err
);

    logic                 accept_c;
    logic [cnt_width-1:0] count_nxt;

    // Gate on the registered non-zero flag only, so a same-cycle inc
    // can never enable a dec.
    always_comb begin
        accept_c  = dec & nz;
        count_nxt = count - cnt_width'(accept_c) + cnt_width'(inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= cnt_width'(init_val);
            nz    <= (init_val != 0);
            err   <= 1'b0;
        end else begin
            count <= count_nxt;
            nz    <= (count_nxt != '0);
            err   <= err | (dec & ~nz);
        end
    end

endmodule

// File: rtl/base_emux_ocrd.sv
// Output credit buffer behind the fixed-latency select mux.
// Issues into the mux consume credits; mux results land in a depth-entry
// FIFO and drain through a valid/ready port; each dequeue returns a credit.
//  clk, reset  clock, async active-low reset
//  i_issue     issuer launched a select this cycle (consumes a credit)
//  o_crd_ok    credits != 0, registered
//  o_credits   current credit count
//  d_v/d_d/d_a mux result valid, data, aux
//  o_v/o_r     FIFO head valid / consumer ready
//  o_d/o_a     FIFO head data / aux (registered)
//  o_err_crd   sticky: issue seen with no credits
//  o_err_ovf   sticky: write dropped at full with no dequeue
module base_emux_ocrd
    import base_emux_pkg::*;
#(
    parameter int unsigned width     = 1,
    parameter int unsigned aux_width = 1,
    parameter int unsigned depth     = 8,
    parameter int unsigned cnt_width = cnt_w(depth)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_issue,
    output logic                 o_crd_ok,
    output logic [cnt_width-1:0] o_credits,
    input  logic                 d_v,
    input  logic [width-1:0]     d_d,
    input  logic [aux_width-1:0] d_a,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [width-1:0]     o_d,
    output logic [aux_width-1:0] o_a,
    output logic                 o_err_crd,
    output logic                 o_err_ovf
);

    localparam int unsigned ptr_width   = ptr_w(depth);
    localparam int unsigned entry_width = width + aux_width;

    logic [entry_width-1:0] mem [depth];
    logic [entry_width-1:0] head;
    logic [entry_width-1:0] head_nxt;
    logic [ptr_width-1:0]   rd_ptr, rd_ptr_nxt;
    logic [ptr_width-1:0]   wr_ptr, wr_ptr_nxt;
    logic [cnt_width-1:0]   occ, occ_nxt;
    logic                   rd_en, wr_en, full;

    // Credit accounting: one credit back per dequeue.
    base_credit_cnt #(
        .cnt_width (cnt_width),
        .init_val  (depth)
    ) u_crd (
        .clk   (clk),
        .rst_n (reset),
        .dec   (i_issue),
        .inc   (rd_en),
        .count (o_credits),
        .nz    (o_crd_ok),
        .err   (o_err_crd)
    );

    // FIFO control. A write at full is accepted only when a dequeue frees
    // the slot in the same cycle.
    always_comb begin
        rd_en      = o_v & o_r;
        full       = (occ == cnt_width'(depth));
        wr_en      = d_v & (~full | rd_en);
        rd_ptr_nxt = rd_en ? ptr_width'(ptr_wrap(32'(rd_ptr), depth)) : rd_ptr;
        wr_ptr_nxt = wr_en ? ptr_width'(ptr_wrap(32'(wr_ptr), depth)) : wr_ptr;
        occ_nxt    = occ + cnt_width'(wr_en) - cnt_width'(rd_en);
        // Next head is the entry being written when it lands at the next
        // read slot (write into an empty or draining FIFO), else storage.
        if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = {d_d, d_a};
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage array, no reset on data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {d_d, d_a};
        end
    end

    // Pointers, occupancy, head register and overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            o_v       <= 1'b0;
            head      <= '0;
            o_err_ovf <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            occ       <= occ_nxt;
            o_v       <= (occ_nxt != '0);
            head      <= head_nxt;
            o_err_ovf <= o_err_ovf | (d_v & full & ~rd_en);
        end
    end

    assign o_d = head[entry_width-1:aux_width];
    assign o_a = head[aux_width-1:0];

endmodule

// File: tb/tb_base_emux_ocrd.sv
module tb_base_emux_ocrd;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned L  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_issue;
    logic          o_crd_ok;
    logic [CW-1:0] o_credits;
    logic          d_v;
    logic [W-1:0]  d_d;
    logic [AW-1:0] d_a;
    logic          o_v;
    logic          o_r;
    logic [W-1:0]  o_d;
    logic [AW-1:0] o_a;
    logic          o_err_crd;
    logic          o_err_ovf;

    base_emux_ocrd #(.width(W), .aux_width(AW), .depth(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_issue   (i_issue),
        .o_crd_ok  (o_crd_ok),
        .o_credits (o_credits),
        .d_v       (d_v),
        .d_d       (d_d),
        .d_a       (d_a),
        .o_v       (o_v),
        .o_r       (o_r),
        .o_d       (o_d),
        .o_a       (o_a),
        .o_err_crd (o_err_crd),
        .o_err_ovf (o_err_ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs for one cycle, expected outputs after the edge.
    typedef struct {
        logic       rst_n, issue, dv, r;
        logic [7:0] d;
        logic       ok;
        logic [2:0] cr;
        logic       ov;
        logic [7:0] od;
        logic       ecrd, eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst_n, input logic issue, input logic dv,
                                input logic [7:0] d, input logic r,
                                input logic ok, input logic [2:0] cr, input logic ov,
                                input logic [7:0] od, input logic ecrd, input logic eovf);
        vec_t v;
        v.rst_n = rst_n; v.issue = issue; v.dv = dv; v.d = d; v.r = r;
        v.ok = ok; v.cr = cr; v.ov = ov; v.od = od; v.ecrd = ecrd; v.eovf = eovf;
        return v;
    endfunction

    // Behavioural reference: credit count, FIFO contents, sticky errors, and
    // an L-stage mux delay line carrying accepted issues.
    int          m_cr;
    logic        m_ecrd, m_eovf;
    logic [9:0]  mq[$];
    logic        pv[L];
    logic [9:0]  pp[L];

    task automatic model_init();
        mq.delete();
        m_cr = D; m_ecrd = 1'b0; m_eovf = 1'b0;
        for (int k = 0; k < L; k++) begin pv[k] = 1'b0; pp[k] = '0; end
    endtask

    task automatic cycle(input logic issue, input logic r, input string tag);
        logic       dv, acc, deq;
        logic [9:0] din;
        int         infl;
        dv  = pv[L-1];
        din = pp[L-1];
        i_issue = issue; o_r = r; d_v = dv; {d_d, d_a} = din;
        deq = (mq.size() != 0) && r;
        acc = issue && (m_cr != 0);
        if (issue && m_cr == 0) m_ecrd = 1'b1;
        if (deq) void'(mq.pop_front());
        if (dv) begin
            if (mq.size() < D) mq.push_back(din);
            else m_eovf = 1'b1;
        end
        m_cr = m_cr - int'(acc) + int'(deq);
        @(posedge clk); #1;
        for (int k = L - 1; k > 0; k--) begin pv[k] = pv[k-1]; pp[k] = pp[k-1]; end
        pv[0] = acc;
        pp[0] = acc ? 10'($urandom) : 10'h0;
        infl = 0;
        for (int k = 0; k < L; k++) infl += int'(pv[k]);
        chk({tag, " credits"}, 32'(o_credits), 32'(m_cr));
        chk({tag, " crd_ok"}, 32'(o_crd_ok), 32'(m_cr != 0));
        chk({tag, " o_v"}, 32'(o_v), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, " head"}, 32'({o_d, o_a}), 32'(mq[0]));
        chk({tag, " errs"}, 32'({o_err_crd, o_err_ovf}), 32'({m_ecrd, m_eovf}));
        chk({tag, " invariant"}, 32'(o_credits) + 32'(mq.size()) + 32'(infl), 32'(D));
    endtask

    initial begin
        int got, issued, gaps;
        logic iss;

        reset = 1'b0; i_issue = 1'b0; d_v = 1'b0; d_d = '0; d_a = '0; o_r = 1'b0;
        model_init();
        repeat (3) @(posedge clk);
        #1;
        chk("reset crd_ok", 32'(o_crd_ok), 32'd1);
        chk("reset credits", 32'(o_credits), 32'd4);
        chk("reset o_v", 32'(o_v), 32'd0);
        chk("reset errs", 32'({o_err_crd, o_err_ovf}), 32'd0);

        // Back-to-back issue with stalled consumer, then drain.
        tbl.push_back(mk(1,1,0,8'h00,0, 1,3,0,8'h00,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0, 1,2,0,8'h00,0,0));
        tbl.push_back(mk(1,1,1,8'h11,0, 1,1,1,8'h11,0,0));
        tbl.push_back(mk(1,1,1,8'h22,0, 0,0,1,8'h11,0,0));
        tbl.push_back(mk(1,0,1,8'h33,0, 0,0,1,8'h11,0,0));
        tbl.push_back(mk(1,0,1,8'h44,0, 0,0,1,8'h11,0,0));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,1,1,8'h22,0,0));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,2,1,8'h33,0,0));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,3,1,8'h44,0,0));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,4,0,8'h00,0,0));
        // Fill, then forced writes at full: with and without a dequeue.
        tbl.push_back(mk(1,1,0,8'h00,0, 1,3,0,8'h00,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0, 1,2,0,8'h00,0,0));
        tbl.push_back(mk(1,1,1,8'hA1,0, 1,1,1,8'hA1,0,0));
        tbl.push_back(mk(1,1,1,8'hA2,0, 0,0,1,8'hA1,0,0));
        tbl.push_back(mk(1,0,1,8'hA3,0, 0,0,1,8'hA1,0,0));
        tbl.push_back(mk(1,0,1,8'hA4,0, 0,0,1,8'hA1,0,0));
        tbl.push_back(mk(1,0,1,8'hA5,1, 1,1,1,8'hA2,0,0));
        tbl.push_back(mk(1,0,1,8'hEE,0, 1,1,1,8'hA2,0,1));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,2,1,8'hA3,0,1));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,3,1,8'hA4,0,1));
        tbl.push_back(mk(1,0,0,8'h00,1, 1,4,1,8'hA5,0,1));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,4,0,8'h00,0,0));
        // Issue at zero credits coinciding with a dequeue.
        tbl.push_back(mk(1,1,0,8'h00,0, 1,3,0,8'h00,0,0));
        tbl.push_back(mk(1,1,0,8'h00,0, 1,2,0,8'h00,0,0));
        tbl.push_back(mk(1,1,1,8'hB1,0, 1,1,1,8'hB1,0,0));
        tbl.push_back(mk(1,1,1,8'hB2,0, 0,0,1,8'hB1,0,0));
        tbl.push_back(mk(1,0,1,8'hB3,0, 0,0,1,8'hB1,0,0));
        tbl.push_back(mk(1,0,1,8'hC4,0, 0,0,1,8'hB1,0,0));
        tbl.push_back(mk(1,1,0,8'h00,1, 1,1,1,8'hB2,1,0));
        tbl.push_back(mk(1,0,0,8'h00,0, 1,1,1,8'hB2,1,0));
        tbl.push_back(mk(0,0,0,8'h00,0, 1,4,0,8'h00,0,0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst_n; i_issue = tbl[i].issue; d_v = tbl[i].dv;
            d_d = tbl[i].d; d_a = tbl[i].d[7:6]; o_r = tbl[i].r;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d crd_ok", i), 32'(o_crd_ok), 32'(tbl[i].ok));
            chk($sformatf("tbl%0d credits", i), 32'(o_credits), 32'(tbl[i].cr));
            chk($sformatf("tbl%0d o_v", i), 32'(o_v), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d o_d", i), 32'(o_d), 32'(tbl[i].od));
                chk($sformatf("tbl%0d o_a", i), 32'(o_a), 32'(tbl[i].od[7:6]));
            end
            chk($sformatf("tbl%0d errs", i), 32'({o_err_crd, o_err_ovf}),
                32'({tbl[i].ecrd, tbl[i].eovf}));
        end

        // Asynchronous reset with three entries held.
        reset = 1'b1;
        model_init();
        repeat (3) cycle(1'b1, 1'b0, "pre-rst");
        repeat (2) cycle(1'b0, 1'b0, "pre-rst");
        reset = 1'b0;
        #1;
        chk("async rst o_v", 32'(o_v), 32'd0);
        chk("async rst credits", 32'(o_credits), 32'd4);
        chk("async rst crd_ok", 32'(o_crd_ok), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        model_init();

        // Streaming 100 items at full rate.
        got = 0; issued = 0; gaps = 0;
        for (int c = 0; c < 400 && got < 100; c++) begin
            iss = (m_cr != 0) && (issued < 100);
            if (iss) issued++;
            if (mq.size() != 0) got++;
            cycle(iss, 1'b1, "stream");
            if (got > 0 && got < 100 && !o_v) gaps++;
            if (got == 50) chk("stream steady credits", 32'(o_credits), 32'(D - L - 1));
        end
        chk("stream items", 32'(got), 32'd100);
        chk("stream gaps", 32'(gaps), 32'd0);

        // Random issue and random ready against the model.
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom % 2 == 0) && (m_cr != 0), ($urandom % 2) == 0, "rand");
        end
        repeat (12) cycle(1'b0, 1'b1, "drain");
        chk("drain empty", 32'(o_v), 32'd0);
        chk("drain credits", 32'(o_credits), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
